// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) types, bit positions and the syndrome function used by
// both the encoder and the serial receiver.
package hamming74_pkg;

    typedef logic [6:0] codeword_t;
    typedef logic [3:0] nibble_t;
    typedef logic [2:0] syndrome_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DECODE,
        S_OUT
    } rx_state_t;

    localparam int D0_POS = 2;
    localparam int D1_POS = 4;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;
    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 3;

    // Each syndrome bit covers the positions whose 1-based index has that bit set.
    function automatic syndrome_t syndrome_of(input codeword_t c);
        syndrome_t s;
        s[0] = c[P0_POS] ^ c[D0_POS] ^ c[D1_POS] ^ c[D3_POS];
        s[1] = c[P1_POS] ^ c[D0_POS] ^ c[D2_POS] ^ c[D3_POS];
        s[2] = c[P2_POS] ^ c[D1_POS] ^ c[D2_POS] ^ c[D3_POS];
        return s;
    endfunction

endpackage

// File: rtl/hamming74_correct.sv
// Combinational single-error correction: received codeword in, corrected
// codeword, raw syndrome and extracted data nibble out.
module hamming74_correct
    import hamming74_pkg::*;
(
    input  logic [6:0] code_in,
    output logic [6:0] code_out,
    output logic [2:0] syndrome,
    output logic [3:0] data
);

    syndrome_t syn;
    codeword_t flip_mask;
    codeword_t fixed;

    always_comb begin
        syn       = syndrome_of(code_in);
        flip_mask = '0;
        if (syn != 3'd0)
            flip_mask = 7'd1 << (syn - 3'd1);
        fixed     = code_in ^ flip_mask;
    end

    assign code_out = fixed;
    assign syndrome = syn;
    assign data     = {fixed[D3_POS], fixed[D2_POS], fixed[D1_POS], fixed[D0_POS]};

endmodule

// File: rtl/hamming74_serial_rx.sv
// Serial Hamming(7,4) receiver: assembles codewords bit-serially, corrects single
// errors and hands out nibbles over valid/ready. Optional HAMMING74_RX_ERRCNT_EN.
module hamming74_serial_rx
    import hamming74_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_data,
    output logic [6:0]       out_code,
    output logic [2:0]       out_syndrome,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             resync,
    output logic [CNT_W-1:0] err_count
);

    rx_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    codeword_t  shreg_q, shreg_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       resync_q, resync_d;
    nibble_t    out_data_q, out_data_d;
    codeword_t  out_code_q, out_code_d;
    syndrome_t  out_syn_q, out_syn_d;
    logic       out_err_q, out_err_d;

    codeword_t  corr_code;
    syndrome_t  corr_syn;
    nibble_t    corr_data;
    logic       accept;

    hamming74_correct u_correct (
        .code_in  (shreg_q),
        .code_out (corr_code),
        .syndrome (corr_syn),
        .data     (corr_data)
    );

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        resync_d   = 1'b0;
        out_data_d = out_data_q;
        out_code_d = out_code_q;
        out_syn_d  = out_syn_q;
        out_err_d  = out_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept && in_start) begin
                    shreg_d = {6'd0, in_bit};
                    cnt_d   = 3'd1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    // A start marker mid-word wins, even on what would be the last bit.
                    if (in_start) begin
                        shreg_d  = {6'd0, in_bit};
                        cnt_d    = 3'd1;
                        resync_d = 1'b1;
                    end else begin
                        shreg_d[cnt_q] = in_bit;
                        cnt_d          = cnt_q + 3'd1;
                        if (cnt_q == 3'd6) begin
                            cnt_d   = 3'd0;
                            state_d = S_DECODE;
                        end
                    end
                end
            end
            S_DECODE: begin
                out_data_d = corr_data;
                out_code_d = corr_code;
                out_syn_d  = corr_syn;
                out_err_d  = (corr_syn != 3'd0);
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE) || (state_d == S_SHIFT);
        out_valid_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            shreg_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            resync_q    <= 1'b0;
            out_data_q  <= '0;
            out_code_q  <= '0;
            out_syn_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            resync_q    <= resync_d;
            out_data_q  <= out_data_d;
            out_code_q  <= out_code_d;
            out_syn_q   <= out_syn_d;
            out_err_q   <= out_err_d;
        end
    end

`ifdef HAMMING74_RX_ERRCNT_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (state_q == S_DECODE && corr_syn != 3'd0 && err_count_q != '1)
            err_count_d = err_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_count_q <= '0;
        else
            err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign resync       = resync_q;
    assign out_data     = out_data_q;
    assign out_code     = out_code_q;
    assign out_syndrome = out_syn_q;
    assign out_err      = out_err_q;

endmodule

// File: tb/tb_hamming74_serial_rx.sv
// Scoreboard bench for hamming74_serial_rx: the driver pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_hamming74_serial_rx;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_bit, in_start, in_valid, out_ready;
    logic             in_ready, out_valid, out_err, resync;
    logic [3:0]       out_data;
    logic [6:0]       out_code;
    logic [2:0]       out_syndrome;
    logic [CNT_W-1:0] err_count;

    hamming74_serial_rx #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_bit       (in_bit),
        .in_start     (in_start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_code     (out_code),
        .out_syndrome (out_syndrome),
        .out_err      (out_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .resync       (resync),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       d;
        logic [6:0]       c;
        logic [2:0]       s;
        logic             e;
        logic [CNT_W-1:0] n;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    int   n_push = 0, n_hs = 0, n_resync = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = c[2] ^ c[4] ^ c[6];
        c[1] = c[2] ^ c[5] ^ c[6];
        c[3] = c[4] ^ c[5] ^ c[6];
        return c;
    endfunction

    task automatic push(input logic [6:0] clean, input logic [3:0] d, input logic [2:0] s);
        exp_t x;
`ifdef HAMMING74_RX_ERRCNT_EN
        if (s != 3'd0 && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        x.n = exp_cnt;
`else
        x.n = '0;
`endif
        x.d = d; x.c = clean; x.s = s; x.e = (s != 3'd0);
        sb.push_back(x);
        n_push++;
    endtask

    // Monitor: one pop per handshake, also counts resync pulses.
    always @(negedge clk) begin
        if (!rst && resync) n_resync++;
        if (!rst && out_valid && out_ready) begin
            n_hs++;
            if (sb.size() == 0) begin
                chk("unexpected_output", {28'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("out_data", out_data, x.d);
                chk("out_code", out_code, x.c);
                chk("out_syndrome", out_syndrome, x.s);
                chk("out_err", out_err, x.e);
                chk("err_count", err_count, x.n);
            end
        end
    end

    task automatic send_bit(input logic b, input logic st);
        logic rdy;
        int   n;
        n = 0;
        in_valid = 1'b1; in_bit = b; in_start = st;
        do begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 100);
        chk("bit_accept", rdy, 1'b1);
        in_valid = 1'b0; in_start = 1'b0;
    endtask

    task automatic send_word(input logic [6:0] w);
        for (int i = 0; i < 7; i++) send_bit(w[i], i == 0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        chk("wait_out_valid", out_valid, 1'b1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset_checks(input logic full);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_resync", resync, 1'b0);
        chk("rst_err_count", err_count, 0);
        if (full) begin
            chk("rst_out_data", out_data, 0);
            chk("rst_out_code", out_code, 0);
            chk("rst_out_syndrome", out_syndrome, 0);
            chk("rst_out_err", out_err, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d words pending", sb.size());
        $fatal(1);
    end

    initial begin
        logic [6:0] cl, rx, snap_code;
        logic [3:0] snap_data;
        int r0;

        rst = 1'b1; in_bit = 1'b0; in_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        do_reset_checks(1'b1);

        // Clean word for nibble 1011, with latency check.
        push(7'b1010101, 4'b1011, 3'd0);
        send_word(7'b1010101);
        @(negedge clk); chk("lat_decode_cycle", out_valid, 1'b0);
        @(negedge clk); chk("lat_out_cycle", out_valid, 1'b1);
        wait_drain();

        // Same word with c[4] flipped.
        push(7'b1010101, 4'b1011, 3'd5);
        send_word(7'b1010101 ^ 7'b0010000);
        wait_drain();

        // All nibbles x (no error + each single-bit error).
        for (int d = 0; d < 16; d++) begin
            for (int e = 0; e < 8; e++) begin
                cl = enc(4'(d));
                rx = (e == 0) ? cl : (cl ^ (7'd1 << (e - 1)));
                push(cl, 4'(d), 3'(e));
                send_word(rx);
            end
        end
        wait_drain();

        // Backpressure: hold the word in OUT for 20 cycles with input pending.
        out_ready = 1'b0;
        push(enc(4'd6), 4'd6, 3'd0);
        send_word(enc(4'd6));
        wait_valid();
        snap_code = out_code; snap_data = out_data;
        in_valid = 1'b1; in_start = 1'b1; in_bit = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_code_stable", out_code, snap_code);
            chk("bp_data_stable", out_data, snap_data);
        end
        in_valid = 1'b0; in_start = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        @(negedge clk); chk("bp_valid_drops", out_valid, 1'b0);
        push(enc(4'd9), 4'd9, 3'd4);
        send_word(enc(4'd9) ^ 7'b0001000);
        wait_drain();

        // Resync: three bits of a partial word, then a fresh start.
        r0 = n_resync;
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        push(enc(4'd12), 4'd12, 3'd0);
        send_word(enc(4'd12));
        wait_drain();
        chk("resync_once", n_resync, r0 + 1);

        // Bits without start in IDLE are dropped silently.
        r0 = n_resync;
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        push(enc(4'd5), 4'd5, 3'd7);
        send_word(enc(4'd5) ^ 7'b1000000);
        wait_drain();
        chk("idle_drop_no_resync", n_resync, r0);

        // Reset in SHIFT with cnt=4.
        cl = enc(4'd3);
        for (int i = 0; i < 4; i++) send_bit(cl[i], i == 0);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        exp_cnt = '0;
        do_reset_checks(1'b0);
        push(enc(4'd3), 4'd3, 3'd2);
        send_word(enc(4'd3) ^ 7'b0000010);
        wait_drain();

        // Reset while a word is held in OUT.
        out_ready = 1'b0;
        push(enc(4'd10), 4'd10, 3'd1);
        send_word(enc(4'd10) ^ 7'b0000001);
        wait_valid();
        void'(sb.pop_back());
        n_push--;
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        exp_cnt = '0;
        do_reset_checks(1'b1);
        out_ready = 1'b1;
        push(enc(4'd14), 4'd14, 3'd0);
        send_word(enc(4'd14));
        wait_drain();

        chk("handshake_count", n_hs, n_push);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
